// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: pulls 64-byte ICache lines into a circular byte
// buffer and presents a decode window at the current RIP.
module fetch_buffer #(
  parameter int LINE_BYTES   = 64,
  parameter int WINDOW_BYTES = 15,
  parameter int NUM_SLOTS    = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        set_rip_i,
  input  logic [63:0]                 new_rip_i,
  output logic                        icache_enable_o,
  output logic [63:0]                 icache_addr_o,
  input  logic [8*LINE_BYTES-1:0]     icache_rdata_i,
  input  logic                        icache_done_i,
  output logic                        decode_valid_o,
  output logic [0:8*WINDOW_BYTES-1]   decode_bytes_o,
  output logic [63:0]                 decode_rip_o,
  input  logic                        consume_i,
  input  logic [7:0]                  bytes_decoded_i
);

  localparam int BUF_BYTES = NUM_SLOTS * LINE_BYTES;
  localparam int IDX_W     = $clog2(BUF_BYTES);
  localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);
  localparam logic [63:0] BUF_SIZE  = 64'(BUF_BYTES);
  localparam logic [63:0] WIN_SIZE  = 64'(WINDOW_BYTES);
  localparam logic [63:0] LINE_SIZE = 64'(LINE_BYTES);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [63:0] head_q, head_d;
  logic [63:0] fetch_q, fetch_d;
  logic        en_q, en_d;
  logic [63:0] addr_q, addr_d;
  logic        line_wr;
  logic [7:0]  buf_q [BUF_BYTES];

  logic [63:0] avail;
  logic [63:0] used;
  logic        have_window;
  logic        slot_free;

  // Right after a mid-line redirect head sits above fetch_addr; the negative
  // difference means nothing is buffered yet.
  assign avail       = fetch_q - head_q;
  assign have_window = !avail[63] && (avail >= WIN_SIZE);
  assign used        = fetch_q - (head_q & LINE_MASK);
  assign slot_free   = used < BUF_SIZE;

  assign decode_valid_o  = have_window && !set_rip_i;
  assign decode_rip_o    = head_q;
  assign icache_enable_o = en_q;
  assign icache_addr_o   = addr_q;

  // Buffer index is the address modulo buffer size, so the window wraps freely.
  for (genvar i = 0; i < WINDOW_BYTES; i++) begin : g_win
    logic [IDX_W-1:0] rd_idx;
    assign rd_idx = head_q[IDX_W-1:0] + IDX_W'(i);
    assign decode_bytes_o[8*i +: 8] = buf_q[rd_idx];
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    fetch_d = fetch_q;
    en_d    = en_q;
    addr_d  = addr_q;
    line_wr = 1'b0;

    if (consume_i && decode_valid_o)
      head_d = head_q + 64'(bytes_decoded_i);

    unique case (state_q)
      IDLE: begin
        if (!set_rip_i && slot_free) begin
          state_d = REQ;
          en_d    = 1'b1;
          addr_d  = fetch_q;
        end
      end
      REQ: begin
        if (icache_done_i) begin
          state_d = IDLE;
          en_d    = 1'b0;
          if (!set_rip_i) begin
            line_wr = !reset_i;
            fetch_d = fetch_q + LINE_SIZE;
          end
        end else if (set_rip_i) begin
          // Request stays on the bus with its old address until it retires.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (icache_done_i) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase

    if (set_rip_i) begin
      head_d  = new_rip_i;
      fetch_d = new_rip_i & LINE_MASK;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      addr_q  <= '0;
      head_q  <= set_rip_i ? new_rip_i : '0;
      fetch_q <= set_rip_i ? (new_rip_i & LINE_MASK) : '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      head_q  <= head_d;
      fetch_q <= fetch_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (line_wr) begin
      for (int k = 0; k < LINE_BYTES; k++)
        buf_q[fetch_q[IDX_W-1:0] + IDX_W'(k)] <= icache_rdata_i[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: line fill, consume, mid-line redirect,
// window wrap, drain of an in-flight request and reset during a request.
module tb_fetch_buffer;

  logic         clk = 1'b0;
  logic         reset, set_rip, icache_enable, icache_done, decode_valid, consume;
  logic [63:0]  new_rip, icache_addr, decode_rip;
  logic [511:0] icache_rdata;
  logic [0:119] decode_bytes;
  logic [7:0]   bytes_decoded;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fetch_buffer dut (
    .clk_i(clk), .reset_i(reset), .set_rip_i(set_rip), .new_rip_i(new_rip),
    .icache_enable_o(icache_enable), .icache_addr_o(icache_addr),
    .icache_rdata_i(icache_rdata), .icache_done_i(icache_done),
    .decode_valid_o(decode_valid), .decode_bytes_o(decode_bytes),
    .decode_rip_o(decode_rip), .consume_i(consume),
    .bytes_decoded_i(bytes_decoded)
  );

  always @(posedge clk)
    assert (!(consume && bytes_decoded > 8'd15)) else $error("bytes_decoded out of range");

  // Line contents: each byte equals the low byte of its own address.
  function automatic logic [511:0] line_of(input logic [63:0] a);
    logic [511:0] d;
    for (int k = 0; k < 64; k++) d[8*k +: 8] = a[7:0] + 8'(k);
    return d;
  endfunction

  function automatic logic [0:119] win_of(input logic [63:0] rip);
    logic [0:119] w;
    for (int i = 0; i < 15; i++) w[8*i +: 8] = rip[7:0] + 8'(i);
    return w;
  endfunction

  task automatic test_reset();
    reset = 1; set_rip = 0; new_rip = '0; icache_done = 0; icache_rdata = '0;
    consume = 0; bytes_decoded = '0;
    repeat (2) @(negedge clk);
    total++; if (icache_enable !== 1'b0) $display("FAIL rst_en got %0b exp 0", icache_enable); else passed++;
    total++; if (icache_addr !== 64'h0) $display("FAIL rst_addr got %h exp 0", icache_addr); else passed++;
    total++; if (decode_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", decode_valid); else passed++;
    total++; if (decode_rip !== 64'h0) $display("FAIL rst_rip got %h exp 0", decode_rip); else passed++;
    set_rip = 1; new_rip = 64'h400000;
    @(negedge clk);
    total++; if (decode_rip !== 64'h400000) $display("FAIL rst_entry_rip got %h exp 400000", decode_rip); else passed++;
    total++; if (icache_enable !== 1'b0) $display("FAIL rst_entry_en got %0b exp 0", icache_enable); else passed++;
    reset = 0; set_rip = 0;
    @(negedge clk);
    total++; if (icache_enable !== 1'b1) $display("FAIL first_req_en got %0b exp 1", icache_enable); else passed++;
    total++; if (icache_addr !== 64'h400000) $display("FAIL first_req_addr got %h exp 400000", icache_addr); else passed++;
    total++; if (decode_valid !== 1'b0) $display("FAIL empty_valid got %0b exp 0", decode_valid); else passed++;
  endtask

  task automatic test_first_line();
    icache_done = 1; icache_rdata = line_of(64'h400000);
    @(negedge clk);
    icache_done = 0;
    total++; if (decode_valid !== 1'b1) $display("FAIL line0_valid got %0b exp 1", decode_valid); else passed++;
    total++; if (decode_rip !== 64'h400000) $display("FAIL line0_rip got %h exp 400000", decode_rip); else passed++;
    total++; if (decode_bytes !== win_of(64'h400000)) $display("FAIL line0_win got %h exp %h", decode_bytes, win_of(64'h400000)); else passed++;
    total++; if (icache_enable !== 1'b0) $display("FAIL idle_gap_en got %0b exp 0", icache_enable); else passed++;
    @(negedge clk);
    total++; if (icache_addr !== 64'h400040 || icache_enable !== 1'b1) $display("FAIL line1_req got en=%0b addr=%h exp en=1 addr=400040", icache_enable, icache_addr); else passed++;
  endtask

  task automatic test_consume();
    consume = 1; bytes_decoded = 8'd3;
    @(negedge clk);
    consume = 0;
    total++; if (decode_rip !== 64'h400003) $display("FAIL cons_rip got %h exp 400003", decode_rip); else passed++;
    total++; if (decode_bytes !== win_of(64'h400003)) $display("FAIL cons_win got %h exp %h", decode_bytes, win_of(64'h400003)); else passed++;
    total++; if (icache_addr !== 64'h400040 || icache_enable !== 1'b1) $display("FAIL req_hold got en=%0b addr=%h exp en=1 addr=400040", icache_enable, icache_addr); else passed++;
    icache_done = 1; icache_rdata = line_of(64'h400040);
    @(negedge clk);
    icache_done = 0;
    total++; if (icache_enable !== 1'b0) $display("FAIL line1_done_en got %0b exp 0", icache_enable); else passed++;
    repeat (3) @(negedge clk);
    total++; if (icache_enable !== 1'b0) $display("FAIL full_en got %0b exp 0", icache_enable); else passed++;
    total++; if (decode_valid !== 1'b1) $display("FAIL full_valid got %0b exp 1", decode_valid); else passed++;
  endtask

  task automatic test_redirect_midline();
    set_rip = 1; new_rip = 64'h400037; consume = 1; bytes_decoded = 8'd5;
    #1;
    total++; if (decode_valid !== 1'b0) $display("FAIL redir_cycle_valid got %0b exp 0", decode_valid); else passed++;
    @(negedge clk);
    set_rip = 0; consume = 0;
    total++; if (decode_rip !== 64'h400037) $display("FAIL redir_rip got %h exp 400037", decode_rip); else passed++;
    total++; if (decode_valid !== 1'b0) $display("FAIL redir_valid got %0b exp 0", decode_valid); else passed++;
    @(negedge clk);
    total++; if (icache_addr !== 64'h400000 || icache_enable !== 1'b1) $display("FAIL redir_req got en=%0b addr=%h exp en=1 addr=400000", icache_enable, icache_addr); else passed++;
    icache_done = 1; icache_rdata = line_of(64'h400000);
    @(negedge clk);
    icache_done = 0;
    total++; if (decode_valid !== 1'b0) $display("FAIL avail9_valid got %0b exp 0", decode_valid); else passed++;
    @(negedge clk);
    total++; if (icache_addr !== 64'h400040 || icache_enable !== 1'b1) $display("FAIL redir_req2 got en=%0b addr=%h exp en=1 addr=400040", icache_enable, icache_addr); else passed++;
    icache_done = 1; icache_rdata = line_of(64'h400040);
    @(negedge clk);
    icache_done = 0;
    total++; if (decode_valid !== 1'b1) $display("FAIL redir_win_valid got %0b exp 1", decode_valid); else passed++;
    total++; if (decode_bytes !== win_of(64'h400037)) $display("FAIL redir_win got %h exp %h", decode_bytes, win_of(64'h400037)); else passed++;
  endtask

  task automatic test_wrap();
    repeat (4) begin
      consume = 1; bytes_decoded = 8'd15;
      @(negedge clk);
    end
    consume = 0;
    total++; if (decode_rip !== 64'h400073) $display("FAIL wrap_rip1 got %h exp 400073", decode_rip); else passed++;
    total++; if (decode_valid !== 1'b0) $display("FAIL avail13_valid got %0b exp 0", decode_valid); else passed++;
    total++; if (icache_addr !== 64'h400080 || icache_enable !== 1'b1) $display("FAIL wrap_req got en=%0b addr=%h exp en=1 addr=400080", icache_enable, icache_addr); else passed++;
    icache_done = 1; icache_rdata = line_of(64'h400080);
    @(negedge clk);
    icache_done = 0;
    total++; if (decode_valid !== 1'b1) $display("FAIL wrap_valid got %0b exp 1", decode_valid); else passed++;
    consume = 1; bytes_decoded = 8'd7;
    @(negedge clk);
    consume = 0;
    total++; if (decode_rip !== 64'h40007A) $display("FAIL wrap_rip2 got %h exp 40007a", decode_rip); else passed++;
    total++; if (decode_bytes !== win_of(64'h40007A)) $display("FAIL wrap_win got %h exp %h", decode_bytes, win_of(64'h40007A)); else passed++;
    consume = 1; bytes_decoded = 8'd6;
    @(negedge clk);
    consume = 0;
    total++; if (icache_enable !== 1'b0) $display("FAIL wrap_full_en got %0b exp 0", icache_enable); else passed++;
    @(negedge clk);
    total++; if (icache_addr !== 64'h4000C0 || icache_enable !== 1'b1) $display("FAIL freed_req got en=%0b addr=%h exp en=1 addr=4000c0", icache_enable, icache_addr); else passed++;
  endtask

  task automatic test_drain();
    set_rip = 1; new_rip = 64'h500000;
    #1;
    total++; if (decode_valid !== 1'b0) $display("FAIL drain_cycle_valid got %0b exp 0", decode_valid); else passed++;
    @(negedge clk);
    set_rip = 0;
    total++; if (icache_addr !== 64'h4000C0 || icache_enable !== 1'b1) $display("FAIL drain_hold1 got en=%0b addr=%h exp en=1 addr=4000c0", icache_enable, icache_addr); else passed++;
    total++; if (decode_rip !== 64'h500000) $display("FAIL drain_rip got %h exp 500000", decode_rip); else passed++;
    repeat (2) @(negedge clk);
    total++; if (icache_addr !== 64'h4000C0 || icache_enable !== 1'b1) $display("FAIL drain_hold3 got en=%0b addr=%h exp en=1 addr=4000c0", icache_enable, icache_addr); else passed++;
    icache_done = 1; icache_rdata = line_of(64'h4000C0);
    @(negedge clk);
    icache_done = 0;
    total++; if (icache_enable !== 1'b0) $display("FAIL drain_done_en got %0b exp 0", icache_enable); else passed++;
    total++; if (decode_valid !== 1'b0) $display("FAIL drain_drop_valid got %0b exp 0", decode_valid); else passed++;
    @(negedge clk);
    total++; if (icache_addr !== 64'h500000 || icache_enable !== 1'b1) $display("FAIL drain_next_req got en=%0b addr=%h exp en=1 addr=500000", icache_enable, icache_addr); else passed++;
  endtask

  task automatic test_reset_in_req();
    reset = 1;
    @(negedge clk);
    reset = 0;
    total++; if (icache_enable !== 1'b0) $display("FAIL rreq_en got %0b exp 0", icache_enable); else passed++;
    total++; if (decode_valid !== 1'b0) $display("FAIL rreq_valid got %0b exp 0", decode_valid); else passed++;
    total++; if (decode_rip !== 64'h0) $display("FAIL rreq_rip got %h exp 0", decode_rip); else passed++;
    icache_done = 1; icache_rdata = line_of(64'h500000);
    @(negedge clk);
    icache_done = 0;
    total++; if (icache_addr !== 64'h0 || icache_enable !== 1'b1) $display("FAIL late_done_req got en=%0b addr=%h exp en=1 addr=0", icache_enable, icache_addr); else passed++;
    total++; if (decode_valid !== 1'b0) $display("FAIL late_done_valid got %0b exp 0", decode_valid); else passed++;
    @(negedge clk);
    total++; if (icache_enable !== 1'b1) $display("FAIL late_done_hold got %0b exp 1", icache_enable); else passed++;
    icache_done = 1; icache_rdata = line_of(64'h0);
    @(negedge clk);
    icache_done = 0;
    total++; if (decode_bytes !== win_of(64'h0) || decode_valid !== 1'b1) $display("FAIL zero_win got v=%0b %h exp v=1 %h", decode_valid, decode_bytes, win_of(64'h0)); else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    total++; if (icache_addr !== 64'h40 || icache_enable !== 1'b1) $display("FAIL b2b_req got en=%0b addr=%h exp en=1 addr=40", icache_enable, icache_addr); else passed++;
    set_rip = 1; new_rip = 64'h600010; icache_done = 1; icache_rdata = line_of(64'h40);
    @(negedge clk);
    set_rip = 0; icache_done = 0;
    total++; if (icache_enable !== 1'b0) $display("FAIL redir_done_en got %0b exp 0", icache_enable); else passed++;
    total++; if (decode_rip !== 64'h600010) $display("FAIL redir_done_rip got %h exp 600010", decode_rip); else passed++;
    total++; if (decode_valid !== 1'b0) $display("FAIL redir_done_valid got %0b exp 0", decode_valid); else passed++;
    @(negedge clk);
    total++; if (icache_addr !== 64'h600000 || icache_enable !== 1'b1) $display("FAIL redir_done_req got en=%0b addr=%h exp en=1 addr=600000", icache_enable, icache_addr); else passed++;
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_consume();
    test_redirect_midline();
    test_wrap();
    test_drain();
    test_reset_in_req();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
